// File: rtl/hex_led_pkg.sv
// hex_led_pkg: shared constants for the seven-segment display controller.
// Register map, CTRL bit positions and the active-high hex segment table.
package hex_led_pkg;

   localparam int MAX_DIGITS = 8;

   localparam logic [1:0] ADDR_VALUE = 2'd0;
   localparam logic [1:0] ADDR_DP    = 2'd1;
   localparam logic [1:0] ADDR_CTRL  = 2'd2;
   localparam logic [1:0] ADDR_BLANK = 2'd3;

   localparam int CTRL_EN       = 0;
   localparam int CTRL_LZS      = 1;
   localparam int CTRL_BLINK    = 2;
   localparam int CTRL_MASK_LSB = 8;

   // Index n holds the pattern for hex digit n; bit 0 = segment a.
   localparam logic [15:0][6:0] SEG_LUT = {
      7'h71, 7'h79, 7'h5E, 7'h39,
      7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66,
      7'h4F, 7'h5B, 7'h06, 7'h3F
   };

endpackage

// File: rtl/hex_seg7_decode.sv
// hex_seg7_decode: nibble to active-high segments a..g.
// Ports: nib_i (hex value), seg_o (bit 0 = a ... bit 6 = g).
module hex_seg7_decode
   import hex_led_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);

   assign seg_o = SEG_LUT[nib_i];

endmodule

// File: rtl/hex_led_ctrl.sv
// hex_led_ctrl: register-mapped multi-digit seven-segment controller.
// Ports: iCLOCK/iRESET_N, write/read port (iWR,iRD,iADDR,iDATA,oREADDATA), oHEX.
module hex_led_ctrl
   import hex_led_pkg::*;
#(
   parameter int NUM_DIGITS = 8,
   parameter int BLINK_DIV  = 25000000,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                    iCLOCK,
   input  logic                    iRESET_N,
   input  logic                    iWR,
   input  logic                    iRD,
   input  logic [1:0]              iADDR,
   input  logic [31:0]             iDATA,
   output logic [31:0]             oREADDATA,
   output logic [8*NUM_DIGITS-1:0] oHEX
);

   localparam int ND = NUM_DIGITS;
   localparam int VW = 4 * ND;
   localparam int CW = $clog2(BLINK_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);
   localparam logic [7:0] ZERO_HI = {1'b0, SEG_LUT[0]};
   localparam logic [7:0] ZERO_OUT = (ACTIVE_LOW != 0) ? ~ZERO_HI : ZERO_HI;

   logic [VW-1:0]   value_q;
   logic [ND-1:0]   dp_q;
   logic            en_q;
   logic            lzs_q;
   logic            blen_q;
   logic [ND-1:0]   mask_q;
   logic [ND-1:0]   blank_q;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            phase_q, phase_d;
   logic [31:0]     rdata_q, rdata_d;
   logic [8*ND-1:0] hex_q, hex_d;

   logic            wr_value, wr_dp, wr_ctrl, wr_blank;
   logic [ND-1:0]   tail_zero;
   logic            zacc;
   logic [ND-1:0]   lit;
   logic [6:0]      seg [ND];
   logic [8*ND-1:0] hex_hi;
   logic            unused_data;

   assign unused_data = ^iDATA;

   assign wr_value = iWR && (iADDR == ADDR_VALUE);
   assign wr_dp    = iWR && (iADDR == ADDR_DP);
   assign wr_ctrl  = iWR && (iADDR == ADDR_CTRL);
   assign wr_blank = iWR && (iADDR == ADDR_BLANK);

   always_comb begin
      rdata_d = rdata_q;
      if (iRD) begin
         rdata_d = '0;
         unique case (iADDR)
            ADDR_VALUE: rdata_d[VW-1:0] = value_q;
            ADDR_DP:    rdata_d[ND-1:0] = dp_q;
            ADDR_CTRL: begin
               rdata_d[CTRL_EN]    = en_q;
               rdata_d[CTRL_LZS]   = lzs_q;
               rdata_d[CTRL_BLINK] = blen_q;
               rdata_d[CTRL_MASK_LSB +: ND] = mask_q;
            end
            default:    rdata_d[ND-1:0] = blank_q;
         endcase
      end
   end

   // A CTRL write restarts the blink period from phase 0.
   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (wr_ctrl || !blen_q) begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // tail_zero[d]: nibbles d..ND-1 are all zero.
   always_comb begin
      tail_zero = '0;
      zacc      = 1'b1;
      for (int d = ND - 1; d >= 0; d--) begin
         zacc = zacc && (value_q[4*d +: 4] == 4'h0);
         tail_zero[d] = zacc;
      end
   end

   for (genvar g = 0; g < ND; g++) begin : g_dec
      hex_seg7_decode u_dec (
         .nib_i (value_q[4*g +: 4]),
         .seg_o (seg[g])
      );
   end

   always_comb begin
      lit    = '0;
      hex_hi = '0;
      for (int d = 0; d < ND; d++) begin
         lit[d] = en_q && !blank_q[d]
                  && !(blen_q && mask_q[d] && phase_q)
                  && !(lzs_q && (d != 0) && tail_zero[d]);
         hex_hi[8*d +: 8] = lit[d] ? {dp_q[d], seg[d]} : 8'h00;
      end
      hex_d = (ACTIVE_LOW != 0) ? ~hex_hi : hex_hi;
   end

   always_ff @(posedge iCLOCK or negedge iRESET_N) begin
      if (!iRESET_N) begin
         value_q <= '0;
         dp_q    <= '0;
         en_q    <= 1'b1;
         lzs_q   <= 1'b0;
         blen_q  <= 1'b0;
         mask_q  <= '0;
         blank_q <= '0;
         cnt_q   <= '0;
         phase_q <= 1'b0;
         rdata_q <= '0;
         hex_q   <= {ND{ZERO_OUT}};
      end else begin
         if (wr_value) value_q <= iDATA[VW-1:0];
         if (wr_dp)    dp_q    <= iDATA[ND-1:0];
         if (wr_ctrl) begin
            en_q   <= iDATA[CTRL_EN];
            lzs_q  <= iDATA[CTRL_LZS];
            blen_q <= iDATA[CTRL_BLINK];
            mask_q <= iDATA[CTRL_MASK_LSB +: ND];
         end
         if (wr_blank) blank_q <= iDATA[ND-1:0];
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         rdata_q <= rdata_d;
         hex_q   <= hex_d;
      end
   end

   assign oREADDATA = rdata_q;
   assign oHEX      = hex_q;

endmodule

// File: tb/tb_hex_led_ctrl.sv
// tb_hex_led_ctrl: directed table, corner sequences and random traffic
// on an 8-digit active-low instance and a 4-digit active-high instance.
module tb_hex_led_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr = 1'b0;
   logic        rd = 1'b0;
   logic [1:0]  addr = 2'd0;
   logic [31:0] data = 32'd0;
   logic [31:0] rd8, rd4;
   logic [63:0] hex8;
   logic [31:0] hex4;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   hex_led_ctrl #(.NUM_DIGITS(8), .BLINK_DIV(4), .ACTIVE_LOW(1)) dut8 (
      .iCLOCK(clk), .iRESET_N(rst_n), .iWR(wr), .iRD(rd),
      .iADDR(addr), .iDATA(data), .oREADDATA(rd8), .oHEX(hex8)
   );

   hex_led_ctrl #(.NUM_DIGITS(4), .BLINK_DIV(3), .ACTIVE_LOW(0)) dut4 (
      .iCLOCK(clk), .iRESET_N(rst_n), .iWR(wr), .iRD(rd),
      .iADDR(addr), .iDATA(data), .oREADDATA(rd4), .oHEX(hex4)
   );

   int NN[2]  = '{8, 4};
   int DIV[2] = '{4, 3};
   int AL[2]  = '{1, 0};
   logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                            7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                            7'h39, 7'h5E, 7'h79, 7'h71};

   logic [31:0] m_val[2], m_dp[2], m_ctrl[2], m_blank[2], m_rd[2];
   logic [63:0] m_hex[2];
   int          m_cnt[2];
   bit          m_ph[2];

   function automatic logic [31:0] vmask(int i);
      return (NN[i] == 8) ? 32'hFFFF_FFFF : (32'h1 << (4 * NN[i])) - 1;
   endfunction

   function automatic logic [31:0] dmask(int i);
      return (32'h1 << NN[i]) - 1;
   endfunction

   function automatic logic [63:0] exp_hex(int i, logic [31:0] v,
         logic [31:0] dp, logic [31:0] c, logic [31:0] b, bit ph);
      logic [63:0] r = '0;
      logic [7:0]  by;
      logic [3:0]  nib;
      bit          on;
      for (int d = 0; d < NN[i]; d++) begin
         nib = 4'((v >> (4 * d)) & 32'hF);
         on  = c[0] && !b[d] && !(c[2] && c[8 + d] && ph)
               && !(c[1] && d > 0 && (v >> (4 * d)) == 0);
         by  = on ? {dp[d], SEG[nib]} : 8'h00;
         if (AL[i] != 0) by = ~by;
         r[8 * d +: 8] = by;
      end
      return r;
   endfunction

   function automatic logic [31:0] rdreg(int i, logic [1:0] a);
      case (a)
         2'd0:    return m_val[i];
         2'd1:    return m_dp[i];
         2'd2:    return m_ctrl[i];
         default: return m_blank[i];
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_val[i] = 0; m_dp[i] = 0; m_ctrl[i] = 1; m_blank[i] = 0;
         m_rd[i] = 0; m_cnt[i] = 0; m_ph[i] = 0;
         m_hex[i] = exp_hex(i, 0, 0, 1, 0, 0);
      end
   endtask

   task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(logic w, logic r, logic [1:0] a, logic [31:0] d);
      wr = w; rd = r; addr = a; data = d;
   endtask

   task automatic tick();
      logic [63:0] nh[2];
      logic [31:0] nr[2], nv[2], nd[2], nc[2], nb[2];
      int          ncnt[2];
      bit          nph[2];
      for (int i = 0; i < 2; i++) begin
         nh[i] = exp_hex(i, m_val[i], m_dp[i], m_ctrl[i], m_blank[i], m_ph[i]);
         nr[i] = rd ? rdreg(i, addr) : m_rd[i];
         nv[i] = m_val[i]; nd[i] = m_dp[i];
         nc[i] = m_ctrl[i]; nb[i] = m_blank[i];
         if (wr) begin
            case (addr)
               2'd0: nv[i] = data & vmask(i);
               2'd1: nd[i] = data & dmask(i);
               2'd2: nc[i] = data & (32'h7 | (dmask(i) << 8));
               default: nb[i] = data & dmask(i);
            endcase
         end
         if ((wr && addr == 2'd2) || !m_ctrl[i][2]) begin
            ncnt[i] = 0; nph[i] = 0;
         end else if (m_cnt[i] == DIV[i] - 1) begin
            ncnt[i] = 0; nph[i] = !m_ph[i];
         end else begin
            ncnt[i] = m_cnt[i] + 1; nph[i] = m_ph[i];
         end
      end
      @(posedge clk);
      #1;
      if (!rst_n) model_reset();
      else begin
         for (int i = 0; i < 2; i++) begin
            m_hex[i] = nh[i]; m_rd[i] = nr[i]; m_val[i] = nv[i];
            m_dp[i] = nd[i]; m_ctrl[i] = nc[i]; m_blank[i] = nb[i];
            m_cnt[i] = ncnt[i]; m_ph[i] = nph[i];
         end
      end
      check("hex8", hex8, m_hex[0]);
      check("rd8", {32'b0, rd8}, {32'b0, m_rd[0]});
      check("hex4", {32'b0, hex4}, m_hex[1]);
      check("rd4", {32'b0, rd4}, {32'b0, m_rd[1]});
   endtask

   typedef struct {
      logic [1:0]  a;
      logic [31:0] d;
      logic [63:0] hex;
      logic [31:0] rdv;
   } vec_t;

   vec_t tbl[11];
   logic [11:0] pat;
   logic [3:0]  pat2;
   logic [31:0] rnd;

   initial begin
      tbl[0]  = '{2'd0, 32'h12345678, 64'hF9A4B0999282F880, 32'h12345678};
      tbl[1]  = '{2'd2, 32'h00000003, 64'hF9A4B0999282F880, 32'h00000003};
      tbl[2]  = '{2'd0, 32'h000000A0, 64'hFFFFFFFFFFFF88C0, 32'h000000A0};
      tbl[3]  = '{2'd0, 32'h00000000, 64'hFFFFFFFFFFFFFFC0, 32'h00000000};
      tbl[4]  = '{2'd2, 32'h00000001, 64'hC0C0C0C0C0C0C0C0, 32'h00000001};
      tbl[5]  = '{2'd1, 32'h00000001, 64'hC0C0C0C0C0C0C040, 32'h00000001};
      tbl[6]  = '{2'd3, 32'h00000002, 64'hC0C0C0C0C0C0FF40, 32'h00000002};
      tbl[7]  = '{2'd0, 32'hFEDCBA98, 64'h8E86A1C68388FF00, 32'hFEDCBA98};
      tbl[8]  = '{2'd2, 32'hFFFFFF00, 64'hFFFFFFFFFFFFFFFF, 32'h0000FF00};
      tbl[9]  = '{2'd2, 32'h00000001, 64'h8E86A1C68388FF00, 32'h00000001};
      tbl[10] = '{2'd0, 32'hFFFF1234, 64'h8E8E8E8EF9A4FF19, 32'hFFFF1234};

      model_reset();
      #12;
      check("reset_hex8", hex8, 64'hC0C0C0C0C0C0C0C0);
      check("reset_hex4", {32'b0, hex4}, 64'h3F3F3F3F);
      check("reset_rd8", {32'b0, rd8}, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      for (int k = 0; k < 11; k++) begin
         drive(1, 0, tbl[k].a, tbl[k].d);
         tick();
         drive(0, 1, tbl[k].a, 0);
         tick();
         drive(0, 0, 0, 0);
         check("tbl_hex", hex8, tbl[k].hex);
         check("tbl_rd", {32'b0, rd8}, {32'b0, tbl[k].rdv});
      end
      check("n4_value_rd", {32'b0, rd4}, 64'h00001234);
      check("n4_hex", {32'b0, hex4}, 64'h065B00E6);

      drive(1, 1, 2'd0, 32'hCAFEF00D);
      tick();
      drive(0, 0, 0, 0);
      check("rd_wr_same_addr", {32'b0, rd8}, 64'hFFFF1234);

      drive(1, 0, 2'd2, 32'h00000305);
      tick();
      drive(0, 0, 0, 0);
      pat = '0;
      for (int j = 0; j < 12; j++) begin
         tick();
         pat[j] = (hex8[7:0] == 8'hFF);
      end
      check("blink_pattern", {52'b0, pat}, 64'h0F0);

      drive(1, 0, 2'd2, 32'h00000305);
      tick();
      drive(0, 0, 0, 0);
      pat2 = '0;
      for (int j = 0; j < 4; j++) begin
         tick();
         pat2[j] = (hex8[7:0] == 8'hFF);
      end
      check("blink_restart", {60'b0, pat2}, 64'h0);

      repeat (5) tick();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      check("async_rst_hex8", hex8, 64'hC0C0C0C0C0C0C0C0);
      check("async_rst_hex4", {32'b0, hex4}, 64'h3F3F3F3F);
      check("async_rst_rd8", {32'b0, rd8}, 64'h0);
      check("async_rst_rd4", {32'b0, rd4}, 64'h0);
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      drive(1, 0, 2'd2, 32'h00000F05);
      tick();
      drive(0, 0, 0, 0);
      repeat (10) tick();

      for (int n = 0; n < 1500; n++) begin
         rnd = $urandom;
         drive($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
               2'($urandom_range(0, 3)), rnd);
         if (wr && addr == 2'd2)
            data = (rnd & 32'h0000FF07) | {31'b0, ($urandom_range(0, 7) != 0)};
         if (wr && addr == 2'd0 && rnd[0])
            data = rnd & 32'h000000FF;
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
